// File: rtl/ghost_mover.sv
// ghost_mover: movement engine for one maze ghost.
//   Mode FSM (SCATTER/CHASE/FRIGHT/EATEN), per-mode step divider, forced
//   reversal on mode changes, arcade shortest-distance tile choice with
//   no-reverse rule, horizontal tunnel wrap, LFSR wandering in FRIGHT.
// Ports:
//   clk, reset (async, active-high), tick (game-step strobe)
//   pacmanX/pacmanY/pacmanDir  Pac-Man tile and heading (0=U 1=L 2=D 3=R)
//   isChase/isScatter          level mode request (chase wins, neither => chase)
//   frightStart, ghostEaten    energiser pulse / collision in FRIGHT
//   wallUp/Down/Left/Right     walls around the current ghost tile
//   ghostX/ghostY/ghostDir     ghost tile and heading
//   ghostMode                  0=SCATTER 1=CHASE 2=FRIGHT 3=EATEN
//   moved                      1-cycle pulse on the edge that changed position
module ghost_mover #(
  parameter int GRID_W       = 28,
  parameter int GRID_H       = 36,
  parameter int START_X      = 14,
  parameter int START_Y      = 14,
  parameter int CORNER_X     = 27,
  parameter int CORNER_Y     = 0,
  parameter int HOME_X       = 14,
  parameter int HOME_Y       = 17,
  parameter int TARGET_MODE  = 0,
  parameter int MOVE_DIV     = 4,
  parameter int FRIGHT_DIV   = 8,
  parameter int FRIGHT_TICKS = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [5:0] pacmanX,
  input  logic [5:0] pacmanY,
  input  logic [1:0] pacmanDir,
  input  logic       isChase,
  input  logic       isScatter,
  input  logic       frightStart,
  input  logic       ghostEaten,
  input  logic       wallUp,
  input  logic       wallDown,
  input  logic       wallLeft,
  input  logic       wallRight,
  output logic [5:0] ghostX,
  output logic [5:0] ghostY,
  output logic [1:0] ghostDir,
  output logic [1:0] ghostMode,
  output logic       moved
);
  typedef enum logic [1:0] {SCATTER = 2'd0, CHASE = 2'd1, FRIGHT = 2'd2, EATEN = 2'd3} mode_t;

  localparam logic [5:0] MAX_X = 6'(GRID_W - 1);
  localparam logic [5:0] MAX_Y = 6'(GRID_H - 1);
  localparam logic [1:0] DIR_U = 2'd0, DIR_L = 2'd1, DIR_D = 2'd2, DIR_R = 2'd3;

  mode_t            mode, modeNext, reqMode;
  logic [15:0]      divCnt, divLimit, frightCnt, lfsr;
  logic             revPending, atHome, stepNow;
  logic [5:0]       tgtX, tgtY;
  logic signed [7:0] aheadX, aheadY;
  logic [3:0][5:0]  nbrX, nbrY;
  logic [3:0]       openDir, cand;
  logic [1:0]       revDir, bestDir, rndDir, nextDir;
  logic [14:0]      bestDist, curDist;
  logic             bestFound, rndFound, takeRev, go;

  // Squared Euclidean distance with signed 8-bit deltas; |d| <= 63 so the
  // sum always fits in 15 bits.
  function automatic logic [14:0] dist2(input logic [5:0] ax, input logic [5:0] ay,
                                        input logic [5:0] bx, input logic [5:0] by);
    logic signed [7:0] dx, dy;
    logic [6:0] ux, uy;
    dx = $signed({2'b00, ax}) - $signed({2'b00, bx});
    dy = $signed({2'b00, ay}) - $signed({2'b00, by});
    ux = dx[7] ? 7'(-dx) : dx[6:0];
    uy = dy[7] ? 7'(-dy) : dy[6:0];
    return 15'(14'(ux) * 14'(ux)) + 15'(14'(uy) * 14'(uy));
  endfunction

  assign ghostMode = mode;
  assign reqMode   = (isChase || !isScatter) ? CHASE : SCATTER;

  always_comb begin
    case (mode)
      FRIGHT:  divLimit = 16'(FRIGHT_DIV - 1);
      EATEN:   divLimit = 16'd0;
      default: divLimit = 16'(MOVE_DIV - 1);
    endcase
  end
  assign stepNow = tick && (divCnt == divLimit);

  // Target tile; FRIGHT ignores it, so it shares the HOME default.
  always_comb begin
    aheadX = $signed({2'b00, pacmanX});
    aheadY = $signed({2'b00, pacmanY});
    case (pacmanDir)
      DIR_U:   aheadY = aheadY - 8'sd4;
      DIR_L:   aheadX = aheadX - 8'sd4;
      DIR_D:   aheadY = aheadY + 8'sd4;
      default: aheadX = aheadX + 8'sd4;
    endcase
    if (aheadX < 8'sd0) aheadX = 8'sd0;
    else if (aheadX > $signed({2'b00, MAX_X})) aheadX = $signed({2'b00, MAX_X});
    if (aheadY < 8'sd0) aheadY = 8'sd0;
    else if (aheadY > $signed({2'b00, MAX_Y})) aheadY = $signed({2'b00, MAX_Y});
    case (mode)
      SCATTER: begin tgtX = 6'(CORNER_X); tgtY = 6'(CORNER_Y); end
      CHASE: begin
        tgtX = (TARGET_MODE == 1) ? aheadX[5:0] : pacmanX;
        tgtY = (TARGET_MODE == 1) ? aheadY[5:0] : pacmanY;
      end
      default: begin tgtX = 6'(HOME_X); tgtY = 6'(HOME_Y); end
    endcase
  end

  // Neighbour tiles (X wraps through the tunnel) and direction choice.
  always_comb begin
    nbrX = {4{ghostX}};
    nbrY = {4{ghostY}};
    nbrY[DIR_U] = ghostY - 6'd1;
    nbrY[DIR_D] = ghostY + 6'd1;
    nbrX[DIR_L] = (ghostX == 6'd0)  ? MAX_X : ghostX - 6'd1;
    nbrX[DIR_R] = (ghostX == MAX_X) ? 6'd0  : ghostX + 6'd1;
    // Grid top/bottom behave as walls; Y never wraps.
    openDir = {~wallRight, ~(wallDown || ghostY == MAX_Y), ~wallLeft, ~(wallUp || ghostY == 6'd0)};
    revDir  = ghostDir ^ 2'd2;
    cand    = openDir & ~(4'b0001 << revDir);

    // Ascending scan with strict '<' gives the U > L > D > R tie order.
    bestDir = DIR_U; bestDist = '1; bestFound = 1'b0; curDist = '0;
    for (int d = 0; d < 4; d++) begin
      curDist = dist2(nbrX[d], nbrY[d], tgtX, tgtY);
      if (cand[d] && (!bestFound || curDist < bestDist)) begin
        bestFound = 1'b1; bestDist = curDist; bestDir = 2'(d);
      end
    end

    rndDir = lfsr[1:0]; rndFound = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!rndFound && cand[2'(lfsr[1:0] + 2'(k))]) begin
        rndFound = 1'b1; rndDir = 2'(lfsr[1:0] + 2'(k));
      end
    end

    takeRev = revPending && openDir[revDir];
    go      = 1'b1;
    if (takeRev)            nextDir = revDir;
    else if (|cand)         nextDir = (mode == FRIGHT) ? rndDir : bestDir;
    else if (openDir[revDir]) nextDir = revDir;
    else begin              nextDir = ghostDir; go = 1'b0; end
  end

  always_comb begin
    modeNext = mode;
    case (mode)
      SCATTER, CHASE: modeNext = frightStart ? FRIGHT : reqMode;
      FRIGHT: begin
        if (ghostEaten) modeNext = EATEN;
        else if (!frightStart && tick && frightCnt <= 16'd1) modeNext = reqMode;
      end
      default: if (atHome) modeNext = reqMode;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghostX <= 6'(START_X); ghostY <= 6'(START_Y); ghostDir <= DIR_L;
      mode <= SCATTER; moved <= 1'b0; divCnt <= '0; frightCnt <= '0;
      revPending <= 1'b0; atHome <= 1'b0; lfsr <= 16'hACE1;
    end else begin
      moved  <= 1'b0;
      atHome <= 1'b0;
      if (tick) begin
        if (stepNow) begin
          divCnt <= '0;
          lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
          if (go) begin
            ghostX   <= nbrX[nextDir];
            ghostY   <= nbrY[nextDir];
            ghostDir <= nextDir;
            moved    <= 1'b1;
            if (takeRev) revPending <= 1'b0;
            if (mode == EATEN && nbrX[nextDir] == 6'(HOME_X) && nbrY[nextDir] == 6'(HOME_Y))
              atHome <= 1'b1;
          end
        end else begin
          divCnt <= divCnt + 16'd1;
        end
      end

      // Placed after the step so a mode-change reversal request survives a
      // same-cycle reverse step, and a mode change always restarts the divider.
      case (mode)
        SCATTER, CHASE: begin
          if (modeNext != mode) revPending <= 1'b1;
          if (frightStart) frightCnt <= 16'(FRIGHT_TICKS);
        end
        FRIGHT: begin
          if (ghostEaten) frightCnt <= '0;
          else if (frightStart) frightCnt <= 16'(FRIGHT_TICKS);
          else if (tick && frightCnt != 16'd0) frightCnt <= frightCnt - 16'd1;
        end
        default: ;
      endcase
      if (modeNext != mode) divCnt <= '0;
      mode <= modeNext;
    end
  end
endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: table-driven vectors plus hand sequences for the mode and
// boundary corners; expected records go through a scoreboard queue.
module tb_ghost_mover;
  localparam int MOVE_DIV = 4;

  logic clk = 1'b0, reset, tick, isChase, isScatter, frightStart, ghostEaten;
  logic wallUp, wallDown, wallLeft, wallRight;
  logic [5:0] pacmanX, pacmanY, ghostX, ghostY;
  logic [1:0] pacmanDir, ghostDir, ghostMode;
  logic moved;

  ghost_mover dut (
    .clk(clk), .reset(reset), .tick(tick),
    .pacmanX(pacmanX), .pacmanY(pacmanY), .pacmanDir(pacmanDir),
    .isChase(isChase), .isScatter(isScatter),
    .frightStart(frightStart), .ghostEaten(ghostEaten),
    .wallUp(wallUp), .wallDown(wallDown), .wallLeft(wallLeft), .wallRight(wallRight),
    .ghostX(ghostX), .ghostY(ghostY), .ghostDir(ghostDir), .ghostMode(ghostMode), .moved(moved)
  );

  always #5 clk = ~clk;

  // full=0 means only the mode is checked (position is random in FRIGHT).
  typedef struct { logic full; logic [5:0] x, y; logic [1:0] dir, mode; logic mv; } exp_t;
  typedef struct { logic [3:0] walls; logic [5:0] px, py; exp_t e; } vec_t;

  exp_t sbq[$];
  vec_t tbl[20];
  int nVec = 0, nBad = 0;
  int mX, mY, mDir, mMode;

  function automatic exp_t mk(input logic full, input int x, input int y, input int d,
                              input int m, input logic mv);
    exp_t e;
    e.full = full; e.x = 6'(x); e.y = 6'(y); e.dir = 2'(d); e.mode = 2'(m); e.mv = mv;
    return e;
  endfunction

  function automatic vec_t vec(input logic [3:0] w, input int px, input int py, input exp_t e);
    vec_t v;
    v.walls = w; v.px = 6'(px); v.py = 6'(py); v.e = e;
    return v;
  endfunction

  task automatic cmp(input string name);
    exp_t e;
    logic bad;
    e = sbq.pop_front();
    nVec++;
    if (e.full)
      bad = {ghostX, ghostY, ghostDir, ghostMode, moved} !== {e.x, e.y, e.dir, e.mode, e.mv};
    else
      bad = ghostMode !== e.mode;
    if (bad) begin
      nBad++;
      $display("FAIL %s: got x=%0d y=%0d dir=%0d mode=%0d moved=%0d, want x=%0d y=%0d dir=%0d mode=%0d moved=%0d (full=%0d)",
               name, ghostX, ghostY, ghostDir, ghostMode, moved, e.x, e.y, e.dir, e.mode, e.mv, e.full);
    end
  endtask

  // One clock with tick=t; called and returns at a negedge.
  task automatic cyc(input logic t, input exp_t e, input string name);
    sbq.push_back(e);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0; frightStart = 1'b0; ghostEaten = 1'b0;
    cmp(name);
  endtask

  task automatic moveStep(input int nx, input int ny, input int nd, input string name);
    for (int i = 0; i < MOVE_DIV - 1; i++) cyc(1'b1, mk(1, mX, mY, mDir, mMode, 0), name);
    cyc(1'b1, mk(1, nx, ny, nd, mMode, 1), name);
    mX = nx; mY = ny; mDir = nd;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; isChase = 1'b0; isScatter = 1'b1;
    frightStart = 1'b0; ghostEaten = 1'b0;
    {wallRight, wallDown, wallLeft, wallUp} = 4'b0000;
    pacmanX = 6'd20; pacmanY = 6'd14; pacmanDir = 2'd3;

    // Walls {R,D,L,U}. CHASE, open field toward (20,14), then two U ties, then a dead end.
    tbl[0]  = vec(4'b0000, 20, 14, mk(1, 14, 14, 1, 1, 0));
    tbl[1]  = vec(4'b0000, 20, 14, mk(1, 14, 14, 1, 1, 0));
    tbl[2]  = vec(4'b0000, 20, 14, mk(1, 14, 14, 1, 1, 0));
    tbl[3]  = vec(4'b0000, 20, 14, mk(1, 15, 14, 3, 1, 1));
    tbl[4]  = vec(4'b0000, 20, 14, mk(1, 15, 14, 3, 1, 0));
    tbl[5]  = vec(4'b0000, 20, 14, mk(1, 15, 14, 3, 1, 0));
    tbl[6]  = vec(4'b0000, 20, 14, mk(1, 15, 14, 3, 1, 0));
    tbl[7]  = vec(4'b0000, 20, 14, mk(1, 16, 14, 3, 1, 1));
    tbl[8]  = vec(4'b0000, 17, 13, mk(1, 16, 14, 3, 1, 0));
    tbl[9]  = vec(4'b0000, 17, 13, mk(1, 16, 14, 3, 1, 0));
    tbl[10] = vec(4'b0000, 17, 13, mk(1, 16, 14, 3, 1, 0));
    tbl[11] = vec(4'b0000, 17, 13, mk(1, 16, 13, 0, 1, 1));
    tbl[12] = vec(4'b0000, 15, 12, mk(1, 16, 13, 0, 1, 0));
    tbl[13] = vec(4'b0000, 15, 12, mk(1, 16, 13, 0, 1, 0));
    tbl[14] = vec(4'b0000, 15, 12, mk(1, 16, 13, 0, 1, 0));
    tbl[15] = vec(4'b0000, 15, 12, mk(1, 16, 12, 0, 1, 1));
    tbl[16] = vec(4'b1011, 15, 12, mk(1, 16, 12, 0, 1, 0));
    tbl[17] = vec(4'b1011, 15, 12, mk(1, 16, 12, 0, 1, 0));
    tbl[18] = vec(4'b1011, 15, 12, mk(1, 16, 12, 0, 1, 0));
    tbl[19] = vec(4'b1011, 15, 12, mk(1, 16, 13, 2, 1, 1));

    @(negedge clk); @(negedge clk);
    sbq.push_back(mk(1, 14, 14, 1, 0, 0));
    cmp("resetState");

    reset = 1'b0; isChase = 1'b1; isScatter = 1'b0;
    mX = 14; mY = 14; mDir = 1; mMode = 1;
    cyc(1'b0, mk(1, mX, mY, mDir, mMode, 0), "toChase");

    foreach (tbl[i]) begin
      {wallRight, wallDown, wallLeft, wallUp} = tbl[i].walls;
      pacmanX = tbl[i].px; pacmanY = tbl[i].py;
      cyc(1'b1, tbl[i].e, $sformatf("table%0d", i));
    end
    {wallRight, wallDown, wallLeft, wallUp} = 4'b0000;
    mX = 16; mY = 13; mDir = 2;

    // Run left to X=0, then through the tunnel with U/D walled.
    pacmanX = 6'd0; pacmanY = 6'd13;
    for (int k = 1; k <= 16; k++) moveStep(16 - k, 13, 1, "runLeft");
    wallUp = 1'b1; wallDown = 1'b1;
    moveStep(27, 13, 1, "wrapLeft");
    wallUp = 1'b0; wallDown = 1'b0;

    // Mode flips force reversal (the first also wraps right from X=27).
    isScatter = 1'b1; isChase = 1'b0; mMode = 0;
    cyc(1'b0, mk(1, mX, mY, mDir, mMode, 0), "toScatter");
    moveStep(0, 13, 3, "revWrapRight");
    moveStep(1, 13, 3, "scatterRight");
    isScatter = 1'b0; isChase = 1'b1; mMode = 1;
    cyc(1'b0, mk(1, mX, mY, mDir, mMode, 0), "toChase2");
    moveStep(0, 13, 1, "revLeft");

    // FRIGHT lasts exactly 480 ticks.
    frightStart = 1'b1;
    cyc(1'b0, mk(1, 0, 13, 1, 2, 0), "frightEnter");
    for (int i = 1; i <= 480; i++) cyc(1'b1, mk(0, 0, 0, 0, (i == 480) ? 1 : 2, 0), "fright480");

    // Reload at tick 200 extends FRIGHT to 680 ticks.
    frightStart = 1'b1;
    cyc(1'b0, mk(0, 0, 0, 0, 2, 0), "frightEnter2");
    for (int i = 1; i <= 200; i++) cyc(1'b1, mk(0, 0, 0, 0, 2, 0), "fright680a");
    frightStart = 1'b1;
    cyc(1'b0, mk(0, 0, 0, 0, 2, 0), "frightReload");
    for (int i = 201; i <= 680; i++) cyc(1'b1, mk(0, 0, 0, 0, (i == 680) ? 1 : 2, 0), "fright680b");

    // Reset in the middle of FRIGHT takes effect without a clock edge.
    frightStart = 1'b1;
    cyc(1'b0, mk(0, 0, 0, 0, 2, 0), "frightEnter3");
    for (int i = 0; i < 50; i++) cyc(1'b1, mk(0, 0, 0, 0, 2, 0), "frightMid");
    reset = 1'b1;
    #1;
    sbq.push_back(mk(1, 14, 14, 1, 0, 0));
    cmp("resetMidFright");
    @(negedge clk);
    reset = 1'b0;

    // SCATTER -> FRIGHT -> EATEN (eaten beats a simultaneous frightStart).
    frightStart = 1'b1;
    cyc(1'b0, mk(1, 14, 14, 1, 2, 0), "frightFromScatter");
    frightStart = 1'b1; ghostEaten = 1'b1;
    cyc(1'b0, mk(1, 14, 14, 1, 3, 0), "eatenWins");
    frightStart = 1'b1;
    cyc(1'b0, mk(1, 14, 14, 1, 3, 0), "eatenIgnoresFright");
    cyc(1'b1, mk(1, 15, 14, 3, 3, 1), "eatenRev");
    cyc(1'b1, mk(1, 15, 15, 2, 3, 1), "eatenStep2");
    cyc(1'b1, mk(1, 15, 16, 2, 3, 1), "eatenStep3");
    cyc(1'b1, mk(1, 14, 16, 1, 3, 1), "eatenTieL");
    cyc(1'b1, mk(1, 14, 17, 2, 3, 1), "eatenHome");
    cyc(1'b0, mk(1, 14, 17, 2, 1, 0), "homeExit");
    ghostEaten = 1'b1;
    cyc(1'b0, mk(1, 14, 17, 2, 1, 0), "eatenOutsideFright");

    // Boxed in: the step is consumed but nothing moves.
    {wallRight, wallDown, wallLeft, wallUp} = 4'b1111;
    for (int i = 0; i < MOVE_DIV; i++) cyc(1'b1, mk(1, 14, 17, 2, 1, 0), "allWalled");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
